// File: rtl/parking_sensor_driver_if.sv
// rtl/parking_sensor_driver_if.sv - request/sensor-pattern bundle between requester and sensor driver
interface parking_sensor_driver_if #(
   parameter int CAPACITY = 15,
   parameter int DW       = 4
);
   localparam int CW = $clog2(CAPACITY + 1);

   logic          req_enter;
   logic          req_exit;
   logic [DW-1:0] dwell;
   logic          ready;
   logic [1:0]    ab;
   logic [1:0]    done;
   logic          rejected;
   logic [CW-1:0] count;

   modport master (
      output req_enter, req_exit, dwell,
      input  ready, ab, done, rejected, count
   );

   modport slave (
      input  req_enter, req_exit, dwell,
      output ready, ab, done, rejected, count
   );
endinterface

// File: rtl/parking_sensor_driver.sv
// rtl/parking_sensor_driver.sv - turns enter/exit requests into {A,B} sensor patterns and tracks occupancy
module parking_sensor_driver #(
   parameter int CAPACITY = 15,
   parameter int DW       = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   parking_sensor_driver_if.slave bus
);
   localparam int CW = $clog2(CAPACITY + 1);
   localparam logic [CW-1:0] CAP = CW'(CAPACITY);

   typedef enum logic [2:0] {IDLE, S1, S2, S3, GAP} state_e;

   state_e        state_q, state_d;
   logic          dir_q, dir_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    ab_q, ab_d;
   logic [1:0]    done_q, done_d;
   logic          rejected_q, rejected_d;
   logic          ready_q, ready_d;

   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      dwell_d    = dwell_q;
      cnt_d      = cnt_q;
      count_d    = count_q;
      done_d     = 2'b00;
      rejected_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req_enter || bus.req_exit) begin
               if ((bus.req_enter && bus.req_exit) ||
                   (bus.req_enter && count_q == CAP) ||
                   (bus.req_exit && count_q == '0)) begin
                  rejected_d = 1'b1;
               end else begin
                  state_d = S1;
                  dir_d   = bus.req_enter;
                  dwell_d = bus.dwell;
                  cnt_d   = bus.dwell;
               end
            end
         end
         S1, S2, S3, GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               cnt_d = dwell_q;
               case (state_q)
                  S1: state_d = S2;
                  S2: begin
                     // Event and occupancy change land on the S2->S3 edge together.
                     state_d = S3;
                     done_d  = dir_q ? 2'b10 : 2'b01;
                     count_d = dir_q ? count_q + 1'b1 : count_q - 1'b1;
                  end
                  S3:      state_d = GAP;
                  default: state_d = IDLE;
               endcase
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         S1:      ab_d = dir_d ? 2'b10 : 2'b01;
         S2:      ab_d = 2'b11;
         S3:      ab_d = dir_d ? 2'b01 : 2'b10;
         default: ab_d = 2'b00;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         dir_q      <= 1'b0;
         dwell_q    <= '0;
         cnt_q      <= '0;
         count_q    <= '0;
         ab_q       <= 2'b00;
         done_q     <= 2'b00;
         rejected_q <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         dwell_q    <= dwell_d;
         cnt_q      <= cnt_d;
         count_q    <= count_d;
         ab_q       <= ab_d;
         done_q     <= done_d;
         rejected_q <= rejected_d;
         ready_q    <= ready_d;
      end
   end

   assign bus.ab       = ab_q;
   assign bus.done     = done_q;
   assign bus.rejected = rejected_q;
   assign bus.ready    = ready_q;
   assign bus.count    = count_q;
endmodule
